btn_bounce_gen: RTL

BTN_BOUNCE_GEN -- requirements
Module: btn_bounce_gen

---
 rtl/btn_bounce_gen_pkg.sv | 21 ++
 rtl/btn_bounce_gen_lfsr16.sv | 29 ++
 rtl/btn_bounce_gen.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/btn_bounce_gen_pkg.sv
// Shared types and constants for the bouncy-button emulator.
package btn_bounce_gen_pkg;

  typedef enum logic [2:0] {
    ST_IDLE           = 3'd0,
    ST_PRESS_BOUNCE   = 3'd1,
    ST_HOLD           = 3'd2,
    ST_RELEASE_BOUNCE = 3'd3,
    ST_SETTLE         = 3'd4
  } state_e;

  // Galois feedback mask, applied when the bit shifted out is 1.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Number of toggle pairs in a burst: (r mod max_pairs) + 1, range 1..max_pairs.
  function automatic logic [4:0] pair_count(input logic [3:0] r,
                                            input logic [4:0] max_pairs);
    return ({1'b0, r} % max_pairs) + 5'd1;
  endfunction

endpackage

// File: rtl/btn_bounce_gen_lfsr16.sv
// 16-bit Galois LFSR; steps once per enabled cycle, reloads SEED on reset.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  output logic [15:0] value
);
  import btn_bounce_gen_pkg::*;

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // Right-shift, folding the taps back in when a 1 falls off the bottom.
  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]};
    if (lfsr_q[0]) lfsr_d = lfsr_d ^ LFSR_TAPS;
  end

  // Register advances only on enabled cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     lfsr_q <= SEED;
    else if (ce) lfsr_q <= lfsr_d;
  end

  assign value = lfsr_q;

endmodule

// File: rtl/btn_bounce_gen.sv
// Emulates a raw mechanical button: bouncy press, stable hold, bouncy
// release, stable settle, then a one-clock done pulse.
//
// state             | meaning
// ST_IDLE           | btn low, waiting for start
// ST_PRESS_BOUNCE   | pairs of (high seg, low seg)
// ST_HOLD           | btn high for HOLD_CYCLES enabled cycles
// ST_RELEASE_BOUNCE | pairs of (low seg, high seg)
// ST_SETTLE         | btn low for SETTLE_CYCLES enabled cycles
module btn_bounce_gen
  import btn_bounce_gen_pkg::*;
#(
  parameter int          SEG_WIDTH        = 2,
  parameter int          BOUNCE_PAIRS_MAX = 4,
  parameter int          HOLD_CYCLES      = 40,
  parameter int          SETTLE_CYCLES    = 40,
  parameter logic [15:0] LFSR_SEED        = 16'hACE1
) (
  input  logic clk,
  input  logic rst,
  input  logic ce,
  input  logic start,
  output logic btn,
  output logic busy,
  output logic done
);

  localparam int TMAX = (HOLD_CYCLES > SETTLE_CYCLES) ? HOLD_CYCLES : SETTLE_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [TW-1:0]      TMR_ONE     = TW'(1);
  localparam logic [TW-1:0]      HOLD_LOAD   = TW'(HOLD_CYCLES);
  localparam logic [TW-1:0]      SETTLE_LOAD = TW'(SETTLE_CYCLES);
  localparam logic [SEG_WIDTH:0] SEG_ONE     = (SEG_WIDTH+1)'(1);
  localparam logic [4:0]         PAIRS_MAX   = 5'(BOUNCE_PAIRS_MAX);

  state_e               state_q, state_d;
  logic [4:0]           pairs_q, pairs_d;
  // One extra bit so a segment of 2^SEG_WIDTH cycles is representable.
  logic [SEG_WIDTH:0]   seg_q, seg_d;
  logic                 phase_q, phase_d;   // 0: first half of pair, 1: second
  logic [TW-1:0]        tmr_q, tmr_d;
  logic                 done_q, done_d;

  logic [15:0]          lfsr_val;
  logic [SEG_WIDTH:0]   seg_load;
  logic [4:0]           pairs_load;
  logic                 unused_lfsr_bits;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .ce    (ce),
    .value (lfsr_val)
  );

  assign seg_load         = {1'b0, lfsr_val[SEG_WIDTH-1:0]} + SEG_ONE;
  assign pairs_load       = pair_count(lfsr_val[11:8], PAIRS_MAX);
  assign unused_lfsr_bits = ^lfsr_val;

  // State and counters move only on enabled cycles; done is a bare one-clock pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pairs_q <= '0;
      seg_q   <= '0;
      phase_q <= 1'b0;
      tmr_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= done_d;
      if (ce) begin
        state_q <= state_d;
        pairs_q <= pairs_d;
        seg_q   <= seg_d;
        phase_q <= phase_d;
        tmr_q   <= tmr_d;
      end
    end
  end

  // Next-state and counter update for one enabled cycle.
  always_comb begin
    state_d = state_q;
    pairs_d = pairs_q;
    seg_d   = seg_q;
    phase_d = phase_q;
    tmr_d   = tmr_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_PRESS_BOUNCE;
          pairs_d = pairs_load;
          seg_d   = seg_load;
          phase_d = 1'b0;
        end
      end
      ST_PRESS_BOUNCE, ST_RELEASE_BOUNCE: begin
        if (seg_q == SEG_ONE) begin
          if (phase_q) begin
            phase_d = 1'b0;
            if (pairs_q == 5'd1) begin
              seg_d = '0;
              if (state_q == ST_PRESS_BOUNCE) begin
                state_d = ST_HOLD;
                tmr_d   = HOLD_LOAD;
              end else begin
                state_d = ST_SETTLE;
                tmr_d   = SETTLE_LOAD;
              end
            end else begin
              pairs_d = pairs_q - 5'd1;
              seg_d   = seg_load;
            end
          end else begin
            phase_d = 1'b1;
            seg_d   = seg_load;
          end
        end else begin
          seg_d = seg_q - SEG_ONE;
        end
      end
      ST_HOLD: begin
        if (tmr_q == TMR_ONE) begin
          state_d = ST_RELEASE_BOUNCE;
          tmr_d   = '0;
          pairs_d = pairs_load;
          seg_d   = seg_load;
          phase_d = 1'b0;
        end else begin
          tmr_d = tmr_q - TMR_ONE;
        end
      end
      ST_SETTLE: begin
        if (tmr_q == TMR_ONE) begin
          state_d = ST_IDLE;
          tmr_d   = '0;
          done_d  = ce;
        end else begin
          tmr_d = tmr_q - TMR_ONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from registered state.
  always_comb begin
    btn  = 1'b0;
    busy = (state_q != ST_IDLE);
    done = done_q;
    case (state_q)
      ST_PRESS_BOUNCE:   btn = ~phase_q;
      ST_HOLD:           btn = 1'b1;
      ST_RELEASE_BOUNCE: btn = phase_q;
      default:           btn = 1'b0;
    endcase
  end

endmodule
